alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational `alu` (inputs a, b, fn3, fn7_bit5; output result) between NUM_REQ requesters.
- Each requester presents one operation with a valid/ready handshake. The arbiter grants round-robin, drives the ALU and registers the result.
- The result is returned to the granted requester with a valid/ready handshake.
- Sits between the core's issue stage(s) and the shared ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the grant/response id.

Ports:
- clk  in  1  clock.
- async_rst  in  1  asynchronous active-high reset; one clock, asynchronous active-high, fixed.
- clk_en  in  1  global clock enable; when low, all state holds.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*32  operand A per requester, packed.
- req_b  in  NUM_REQ*32  operand B per requester, packed.
- req_fn3  in  NUM_REQ*3  funct3 per requester.
- req_fn7_bit5  in  NUM_REQ  funct7[5] per requester.
- rsp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  32  registered ALU result, shared by all requesters.
- rsp_id  out  ID_W  index of the requester owning rsp_data.
- alu_a  out  32  to ALU operand a.
- alu_b  out  32  to ALU operand b.
- alu_fn3  out  3  to ALU fn3.
- alu_fn7_bit5  out  1  to ALU fn7_bit5.
- alu_result  in  32  from ALU result.

Behaviour:
- State machine: IDLE, RESP.
- Reset (async, immediate):
  - state=IDLE, rsp_data=0, rsp_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - All rsp_valid=0, all req_ready=0.
- IDLE:
  - Winner = first index with req_valid set, scanning last+1, last+2, … with wrap modulo NUM_REQ.
  - ALU inputs are muxed combinationally from the winner. With no winner, ALU inputs are 0.
  - req_ready[winner]=1 combinationally only when clk_en=1.
  - On that edge: rsp_data<=alu_result, rsp_id<=winner, last<=winner, state<=RESP.
- RESP:
  - rsp_valid[rsp_id]=1; all req_ready=0.
  - When rsp_ready[rsp_id]=1 and clk_en=1: state<=IDLE.
  - rsp_ready of non-owners is ignored.
- Latency and throughput:
  - Accept edge to rsp_valid: 1 cycle.
  - Throughput: one operation per 2 cycles.
- Requester rules:
  - Operands must be stable while req_valid is high and not accepted.
  - A requester may deassert req_valid before acceptance.
- clk_en=0: state, pointer and data hold. req_ready is forced 0; rsp_valid keeps its registered value.
- Simultaneous requests: exactly one grant per accept. A continuously requesting port waits at most NUM_REQ-1 grants.
- Reset during RESP: the pending result is dropped and rsp_valid falls immediately. Requesters must reissue.
- Arithmetic: none inside the block. The ALU result is passed through unmodified, 32-bit.

Optional Feature:
- Macro: ALU_ARBITER_BYPASS_EN.
- Defined:
  - In RESP, when the response is accepted this cycle, the arbiter also arbitrates among req_valid (same pointer rules, last = current rsp_id).
  - If there is a winner, it asserts req_ready, captures the new result and stays in RESP with the new rsp_id. Throughput becomes 1 per cycle.
  - If there is no winner, the state returns to IDLE.
- Undefined: behaviour exactly as above, with no arbitration in RESP.

Decomposition:
- Package alu_arbiter_pkg:
  - State enum alu_arb_state_t {IDLE, RESP}.
  - fn3 localparams ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND=7.
  - Operation struct alu_op_t {a, b, fn3, fn7_bit5}.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ request vector, last pointer.
  - Outputs: one-hot grant, encoded index, any-grant flag.
  - Purely combinational.

Test Plan:
- Reset, then req0: a=10, b=2, fn3=0, fn7_bit5=0 -> req_ready[0] same cycle; next cycle rsp_valid[0]=1, rsp_data=12, rsp_id=0. Repeat with fn7_bit5=1 -> rsp_data=8.
- req0 and req1 both continuously valid; req0 SLT a=2, b=-2; req1 SLTU a=2, b=-2 -> grants alternate 0,1,0,1; req0 responses =0, req1 responses =1.
- Response held: req1 SRA a=32'h80000000, b=31, fn3=5, fn7_bit5=1; rsp_ready low 5 cycles -> rsp_valid[1] and rsp_data=32'hFFFFFFFF stable, no req_ready asserted; accept -> IDLE.
- clk_en=0 while req0 valid (OR a=32'hf00f00f0, b=32'h0ff00000) -> no req_ready, state frozen; clk_en=1 -> accept, rsp_data=32'hffff00f0.
- async_rst pulse mid-RESP, between clock edges -> rsp_valid=0 immediately; the next grant goes to req0 even if req1 is also valid.
- With ALU_ARBITER_BYPASS_EN, stream 4 XORs a=32'hf0ff00ff, b=32'hffffffff from req0, rsp_ready=1 -> one result per cycle, each 32'h0f00ff00.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arbiter_pkg;

  typedef enum logic {
    IDLE,
    RESP
  } alu_arb_state_t;

  localparam logic [2:0] ADD_SUB = 3'd0;
  localparam logic [2:0] SLL     = 3'd1;
  localparam logic [2:0] SLT     = 3'd2;
  localparam logic [2:0] SLTU    = 3'd3;
  localparam logic [2:0] XOR     = 3'd4;
  localparam logic [2:0] SRL_SRA = 3'd5;
  localparam logic [2:0] OR      = 3'd6;
  localparam logic [2:0] AND     = 3'd7;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  fn3;
    logic        fn7_bit5;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the ALU arbiter.
// slave = arbiter side, master = requesters plus the ALU instance.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*3-1:0]  req_fn3;
  logic [NUM_REQ-1:0]    req_fn7_bit5;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [2:0]            alu_fn3;
  logic                  alu_fn7_bit5;
  logic [31:0]           alu_result;

  modport slave (
    input  req_valid, req_a, req_b, req_fn3, req_fn7_bit5, rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_data, rsp_id, alu_a, alu_b, alu_fn3, alu_fn7_bit5
  );

  modport master (
    output req_valid, req_a, req_b, req_fn3, req_fn7_bit5, rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_data, rsp_id, alu_a, alu_b, alu_fn3, alu_fn7_bit5
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first request after i_last, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_pos;

  // Scan from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_pos = ID_W'((32'(i_last) + k) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Define ALU_ARBITER_BYPASS_EN to re-arbitrate in RESP for 1 op/cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          clk_en,
  alu_arbiter_if.slave  bus
);

`ifdef ALU_ARBITER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  alu_arb_state_t     r_state;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_rsp_acc;
  logic               w_take;
  alu_op_t            w_op;

  assign w_arb_req = ((r_state == IDLE) || BYPASS) ? bus.req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req   (w_arb_req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_rsp_acc = (r_state == RESP) && clk_en && bus.rsp_ready[r_rsp_id];
  assign w_take    = clk_en && w_any && ((r_state == IDLE) || (BYPASS && w_rsp_acc));

  always_comb begin
    w_op = '0;
    if (w_any) begin
      w_op.a        = bus.req_a[int'(w_idx)*32 +: 32];
      w_op.b        = bus.req_b[int'(w_idx)*32 +: 32];
      w_op.fn3      = bus.req_fn3[int'(w_idx)*3 +: 3];
      w_op.fn7_bit5 = bus.req_fn7_bit5[w_idx];
    end
  end

  assign bus.alu_a        = w_op.a;
  assign bus.alu_b        = w_op.b;
  assign bus.alu_fn3      = w_op.fn3;
  assign bus.alu_fn7_bit5 = w_op.fn7_bit5;
  assign bus.req_ready    = w_take ? w_grant : '0;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_id       = r_rsp_id;

  // A grant always wins over a plain response release; without bypass
  // w_take can only fire in IDLE, so the ordering is harmless there.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state     <= IDLE;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
    end else if (clk_en) begin
      if (w_take) begin
        r_state     <= RESP;
        r_rsp_data  <= bus.alu_result;
        r_rsp_id    <= w_idx;
        r_last      <= w_idx;
        r_rsp_valid <= w_grant;
      end else if (w_rsp_acc) begin
        r_state     <= IDLE;
        r_rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;
`ifdef ALU_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic async_rst;
  logic clk_en;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .clk_en    (clk_en),
    .bus       (bus)
  );

  logic [N-1:0] t_valid, t_keep, t_rsp_ready;
  logic [31:0]  t_a [N];
  logic [31:0]  t_b [N];
  logic [2:0]   t_fn3 [N];
  logic         t_f7 [N];

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7);
    case (f3)
      ADD_SUB: return f7 ? a - b : a + b;
      SLL:     return a << b[4:0];
      SLT:     return {31'b0, $signed(a) < $signed(b)};
      SLTU:    return {31'b0, a < b};
      XOR:     return a ^ b;
      SRL_SRA: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      OR:      return a | b;
      default: return a & b;
    endcase
  endfunction

  assign bus.req_valid  = t_valid;
  assign bus.rsp_ready  = t_rsp_ready;
  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_fn3, bus.alu_fn7_bit5);
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_a[g*32 +: 32]  = t_a[g];
    assign bus.req_b[g*32 +: 32]  = t_b[g];
    assign bus.req_fn3[g*3 +: 3]  = t_fn3[g];
    assign bus.req_fn7_bit5[g]    = t_f7[g];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one outstanding result, last-granted index.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic [31:0] m_data;

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_data = '0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic f7);
    t_a[i] = a; t_b[i] = b; t_fn3[i] = f3; t_f7[i] = f7;
  endtask

  // One clock: check outputs at negedge, advance the model after posedge.
  task automatic step(output int g);
    int w;
    bit found, acc, grant;
    logic [N-1:0] exp_rdy, exp_rv;
    @(negedge clk);
    w = -1; found = 1'b0;
    for (int d = 1; d <= N; d++) begin
      int i;
      i = (m_last + d) % N;
      if (!found && t_valid[i]) begin w = i; found = 1'b1; end
    end
    acc   = m_busy && clk_en && t_rsp_ready[m_owner];
    grant = clk_en && found && (!m_busy || (BYP && acc));
    exp_rdy = grant ? (N'(1) << w) : '0;
    exp_rv  = m_busy ? (N'(1) << m_owner) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (m_busy) begin
      chk("rsp_data", bus.rsp_data, m_data);
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_owner));
    end else begin
      chk("alu_a", bus.alu_a, found ? t_a[w] : 32'h0);
      chk("alu_b", bus.alu_b, found ? t_b[w] : 32'h0);
      chk("alu_fn", {28'b0, bus.alu_fn3, bus.alu_fn7_bit5},
          found ? {28'b0, t_fn3[w], t_f7[w]} : 32'h0);
    end
    g = grant ? w : -1;
    @(posedge clk);
    #1;
    if (grant) begin
      m_busy = 1'b1; m_owner = w; m_last = w;
      m_data = alu_ref(t_a[w], t_b[w], t_fn3[w], t_f7[w]);
      t_valid[w] = t_keep[w];
    end else if (acc) begin
      m_busy = 1'b0;
    end
  endtask

  initial begin
    int g, g0, g1, cnt;
    async_rst = 1'b1; clk_en = 1'b1;
    t_valid = '0; t_keep = '0; t_rsp_ready = '1;
    for (int i = 0; i < N; i++) set_op(i, 32'h0, 32'h0, 3'd0, 1'b0);
    model_reset();
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    @(posedge clk); #1;
    async_rst = 1'b0;

    // ADD then SUB from requester 0
    set_op(0, 32'd10, 32'd2, ADD_SUB, 1'b0); t_valid[0] = 1'b1;
    step(g);
    chk("add_grant", 32'(g), 32'd0);
    chk("add_rv", 32'(bus.rsp_valid), 32'h1);
    chk("add_data", bus.rsp_data, 32'd12);
    step(g);
    set_op(0, 32'd10, 32'd2, ADD_SUB, 1'b1); t_valid[0] = 1'b1;
    step(g);
    chk("sub_data", bus.rsp_data, 32'd8);
    step(g);

    // Both requesters streaming: grants alternate
    set_op(0, 32'd2, 32'hFFFF_FFFE, SLT, 1'b0);
    set_op(1, 32'd2, 32'hFFFF_FFFE, SLTU, 1'b0);
    t_keep = 2'b11; t_valid = 2'b11; g0 = 0; g1 = 0;
    repeat (8) begin
      step(g);
      if (g == 0) g0++;
      if (g == 1) g1++;
    end
    chk("alt_g0", 32'(g0), BYP ? 32'd4 : 32'd2);
    chk("alt_g1", 32'(g1), BYP ? 32'd4 : 32'd2);
    t_keep = '0; t_valid = '0;
    step(g); step(g);

    // Response held off by rsp_ready
    t_rsp_ready = '0;
    set_op(1, 32'h8000_0000, 32'd31, SRL_SRA, 1'b1); t_valid[1] = 1'b1;
    step(g);
    set_op(0, 32'd1, 32'd1, ADD_SUB, 1'b0); t_valid[0] = 1'b1;
    repeat (5) begin
      step(g);
      chk("hold_data", bus.rsp_data, 32'hFFFF_FFFF);
      chk("hold_rv", 32'(bus.rsp_valid), 32'h2);
    end
    t_rsp_ready = '1;
    step(g);
    t_valid = '0;
    step(g); step(g);

    // Clock enable low freezes everything
    clk_en = 1'b0;
    set_op(0, 32'hf00f_00f0, 32'h0ff0_0000, OR, 1'b0); t_valid[0] = 1'b1;
    repeat (3) step(g);
    clk_en = 1'b1;
    step(g);
    chk("cke_grant", 32'(g), 32'd0);
    chk("cke_data", bus.rsp_data, 32'hffff_00f0);
    step(g);

    // Asynchronous reset between edges while a response is pending
    set_op(1, 32'd5, 32'd7, ADD_SUB, 1'b0); t_valid[1] = 1'b1;
    step(g);
    #1 async_rst = 1'b1;
    #1;
    chk("arst_rv", 32'(bus.rsp_valid), 32'h0);
    chk("arst_data", bus.rsp_data, 32'h0);
    async_rst = 1'b0;
    model_reset();
    t_valid = 2'b11;
    step(g);
    chk("arst_grant", 32'(g), 32'd0);
    chk("arst_id", 32'(bus.rsp_id), 32'd0);
    t_valid = '0;
    step(g); step(g);

    // Single-requester XOR stream with rsp_ready held high
    set_op(0, 32'hf0ff_00ff, 32'hffff_ffff, XOR, 1'b0);
    t_keep[0] = 1'b1; t_valid[0] = 1'b1; cnt = 0;
    repeat (8) begin
      step(g);
      if (bus.rsp_valid == 2'b01 && bus.rsp_data == 32'h0f00_ff00) cnt++;
    end
    chk("stream_cnt", 32'(cnt), BYP ? 32'd8 : 32'd4);
    t_keep = '0; t_valid = '0;
    step(g); step(g);

    // Random traffic against the model
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!t_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            set_op(i, $urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1)));
            t_valid[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          t_valid[i] = 1'b0;
        end
      end
      t_rsp_ready = N'($urandom);
      clk_en = ($urandom_range(4) != 0);
      step(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
